// File: rtl/axi_ram_slave.sv
// axi_ram_slave: single-ID AXI4 slave backed by a 2-port on-chip RAM; stands in for the DDR controller.
// Optional macro AXI_RAM_BOUNDS_EN: out-of-range or wrapping beats answer SLVERR and writes are dropped.
module axi_ram_slave #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 256,
  parameter int MEM_ADDR_W = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awlock,
  input  logic [3:0]          s_axi_awcache,
  input  logic [2:0]          s_axi_awprot,
  input  logic [3:0]          s_axi_awqos,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic                s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic                s_axi_arid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arlock,
  input  logic [3:0]          s_axi_arcache,
  input  logic [2:0]          s_axi_arprot,
  input  logic [3:0]          s_axi_arqos,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic                s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int DEPTH  = 1 << MEM_ADDR_W;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [MEM_ADDR_W-1:0] IDX_ONE = 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_BURST} r_state_e;

  logic [DATA_W-1:0]     r_mem [DEPTH];

  // Holds the ready outputs low for the first cycle after reset release.
  logic                  r_live;

  w_state_e              r_w_state, w_w_next;
  logic                  r_aw_id;
  logic [MEM_ADDR_W-1:0] r_w_addr;
  logic [7:0]            r_aw_len;
  logic [7:0]            r_w_cnt;
  logic                  r_w_err;
  logic                  r_w_oob;
  logic                  r_w_wrap;
  logic                  r_w_bad;
  logic                  w_aw_hs, w_w_hs, w_w_final, w_w_bad, w_mem_we;
  logic                  w_aw_oob, w_ar_oob, w_burst_err;

  r_state_e              r_r_state, w_r_next;
  logic                  r_ar_id;
  logic [7:0]            r_ar_len;
  logic                  r_ar_oob;
  logic [MEM_ADDR_W-1:0] r_rd_addr;
  logic                  r_rd_wrap;
  logic [7:0]            r_iss_cnt;
  logic                  r_iss_pend;
  logic                  r_rd_vld, r_rd_last, r_rd_err;
  logic [DATA_W-1:0]     r_rd_data;
  logic [DATA_W-1:0]     r_buf_data [2];
  logic [1:0]            r_buf_last, r_buf_err;
  logic                  r_buf_wp, r_buf_rp;
  logic [1:0]            r_buf_cnt;
  logic                  w_ar_hs, w_pop, w_head_last, w_room;
  logic [2:0]            w_occ;
  logic                  w_rd_issue, w_iss_last, w_iss_err;
  logic [MEM_ADDR_W-1:0] w_rd_idx;
  logic                  w_unused_ok;

`ifdef AXI_RAM_BOUNDS_EN
  assign w_aw_oob    = |s_axi_awaddr[ADDR_W-1:OFF+MEM_ADDR_W];
  assign w_ar_oob    = |s_axi_araddr[ADDR_W-1:OFF+MEM_ADDR_W];
  assign w_w_bad     = r_w_oob | r_w_wrap;
  assign w_burst_err = r_ar_oob | r_rd_wrap;
`else
  assign w_aw_oob    = 1'b0;
  assign w_ar_oob    = 1'b0;
  assign w_w_bad     = 1'b0;
  assign w_burst_err = 1'b0;
`endif

  // ---------------- write channel ----------------
  assign w_aw_hs   = s_axi_awvalid & s_axi_awready;
  assign w_w_hs    = s_axi_wvalid & s_axi_wready;
  assign w_w_final = (r_w_cnt == r_aw_len);
  assign w_mem_we  = w_w_hs & ~w_w_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_live    <= 1'b0;
      r_w_state <= W_IDLE;
    end else begin
      r_live    <= 1'b1;
      r_w_state <= w_w_next;
    end
  end

  always_comb begin
    w_w_next      = r_w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (r_w_state)
      W_IDLE: begin
        s_axi_awready = r_live;
        if (s_axi_awvalid && r_live) w_w_next = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && w_w_final) w_w_next = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_w_next = W_IDLE;
      end
      default: w_w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_id  <= 1'b0;
      r_w_addr <= '0;
      r_aw_len <= '0;
      r_w_cnt  <= '0;
      r_w_err  <= 1'b0;
      r_w_oob  <= 1'b0;
      r_w_wrap <= 1'b0;
      r_w_bad  <= 1'b0;
    end else if (w_aw_hs) begin
      r_aw_id  <= s_axi_awid;
      r_w_addr <= s_axi_awaddr[OFF +: MEM_ADDR_W];
      r_aw_len <= s_axi_awlen;
      r_w_cnt  <= '0;
      r_w_err  <= 1'b0;
      r_w_oob  <= w_aw_oob;
      r_w_wrap <= 1'b0;
      r_w_bad  <= 1'b0;
    end else if (w_w_hs) begin
      r_w_addr <= r_w_addr + IDX_ONE;
      r_w_cnt  <= r_w_cnt + 8'd1;
      if (s_axi_wlast != w_w_final) r_w_err  <= 1'b1;
      if (&r_w_addr)                r_w_wrap <= 1'b1;
      if (w_w_bad)                  r_w_bad  <= 1'b1;
    end
  end

  assign s_axi_bid   = s_axi_bvalid & r_aw_id;
  assign s_axi_bresp = (s_axi_bvalid && (r_w_err || r_w_bad)) ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) r_mem[r_w_addr][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  assign w_ar_hs     = s_axi_arvalid & s_axi_arready;
  assign w_pop       = s_axi_rvalid & s_axi_rready;
  assign w_head_last = r_buf_last[r_buf_rp];
  // Buffered plus in-flight beats after this cycle's pop must leave a slot for a new read.
  assign w_occ       = {1'b0, r_buf_cnt} + {2'b00, r_rd_vld} - {2'b00, w_pop};
  assign w_room      = (w_occ < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_r_state <= R_IDLE;
    else     r_r_state <= w_r_next;
  end

  always_comb begin
    w_r_next      = r_r_state;
    s_axi_arready = 1'b0;
    case (r_r_state)
      R_IDLE: begin
        s_axi_arready = r_live;
        if (s_axi_arvalid && r_live) w_r_next = R_BURST;
      end
      R_BURST: begin
        if (w_pop && w_head_last) w_r_next = R_IDLE;
      end
      default: w_r_next = R_IDLE;
    endcase
  end

  // Beat 0 is read straight off the AR handshake so data is visible two cycles later.
  always_comb begin
    w_rd_issue = 1'b0;
    w_rd_idx   = r_rd_addr;
    w_iss_last = (r_iss_cnt == r_ar_len);
    w_iss_err  = w_burst_err;
    if (r_r_state == R_IDLE) begin
      w_rd_issue = w_ar_hs;
      w_rd_idx   = s_axi_araddr[OFF +: MEM_ADDR_W];
      w_iss_last = (s_axi_arlen == 8'd0);
      w_iss_err  = w_ar_oob;
    end else if (r_iss_pend && w_room) begin
      w_rd_issue = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ar_id    <= 1'b0;
      r_ar_len   <= '0;
      r_ar_oob   <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_wrap  <= 1'b0;
      r_iss_cnt  <= '0;
      r_iss_pend <= 1'b0;
      r_rd_vld   <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_vld <= w_rd_issue;
      if (w_rd_issue) begin
        r_rd_last  <= w_iss_last;
        r_rd_err   <= w_iss_err;
        r_rd_addr  <= w_rd_idx + IDX_ONE;
        r_rd_wrap  <= ((r_r_state == R_IDLE) ? 1'b0 : r_rd_wrap) | (&w_rd_idx);
        r_iss_cnt  <= (r_r_state == R_IDLE) ? 8'd1 : r_iss_cnt + 8'd1;
        r_iss_pend <= ~w_iss_last;
      end
      if (w_ar_hs) begin
        r_ar_id  <= s_axi_arid;
        r_ar_len <= s_axi_arlen;
        r_ar_oob <= w_ar_oob;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_rd_issue) r_rd_data <= r_mem[w_rd_idx];
  end

  always_ff @(posedge clk) begin
    if (r_rd_vld) r_buf_data[r_buf_wp] <= r_rd_err ? '0 : r_rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_cnt  <= '0;
      r_buf_wp   <= 1'b0;
      r_buf_rp   <= 1'b0;
      r_buf_last <= '0;
      r_buf_err  <= '0;
    end else begin
      if (r_rd_vld) begin
        r_buf_last[r_buf_wp] <= r_rd_last;
        r_buf_err[r_buf_wp]  <= r_rd_err;
        r_buf_wp             <= ~r_buf_wp;
      end
      if (w_pop) r_buf_rp <= ~r_buf_rp;
      r_buf_cnt <= r_buf_cnt + {1'b0, r_rd_vld} - {1'b0, w_pop};
    end
  end

  assign s_axi_rvalid = (r_buf_cnt != 2'd0);
  assign s_axi_rdata  = s_axi_rvalid ? r_buf_data[r_buf_rp] : '0;
  assign s_axi_rlast  = s_axi_rvalid & r_buf_last[r_buf_rp];
  assign s_axi_rresp  = (s_axi_rvalid && r_buf_err[r_buf_rp]) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi_rid    = s_axi_rvalid & r_ar_id;

  assign w_unused_ok = ^{s_axi_awaddr, s_axi_awsize, s_axi_awburst, s_axi_awlock, s_axi_awcache,
                         s_axi_awprot, s_axi_awqos, s_axi_araddr, s_axi_arsize, s_axi_arburst,
                         s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, r_w_oob,
                         r_w_wrap, r_ar_oob, r_rd_wrap, w_aw_oob, w_ar_oob};

endmodule

// File: tb/tb_axi_ram_slave.sv
// tb_axi_ram_slave: directed bench for axi_ram_slave (64-bit data, 64-word RAM).
// Honours AXI_RAM_BOUNDS_EN when the build defines it.
module tb_axi_ram_slave;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int MEM_ADDR_W = 6;
  localparam int DEPTH = 64;
  localparam int WAIT_MAX = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              awid = 0, wlast = 0, awvalid = 0, wvalid = 0, bready = 0;
  logic [ADDR_W-1:0] awaddr = '0, araddr = '0;
  logic [7:0]        awlen = '0, arlen = '0, wstrb = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic              arid = 0, arvalid = 0, rready = 0;
  logic              awready, wready, bid, bvalid, arready, rid, rlast, rvalid;
  logic [1:0]        bresp, rresp;
  logic [DATA_W-1:0] rdata;

  axi_ram_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_ADDR_W(MEM_ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(3'd3),
    .s_axi_awburst(2'b01), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0),
    .s_axi_awqos(4'd0), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(3'd3),
    .s_axi_arburst(2'b01), .s_axi_arlock(1'b0), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
    .s_axi_arqos(4'd0), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [63:0] model [DEPTH];
  logic [63:0] wbeat [256];
  logic [63:0] rd_data [256];
  logic [1:0]  rd_resp [256];
  logic        rd_last [256];
  logic        rd_id [256];
  int          rd_n, rd_gaps, rd_unstable, rd_first_lat;
  logic [1:0]  resp;
  logic        bid_s;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input int len, input logic id, input int wlast_at,
                           input logic [7:0] strb, output logic [1:0] resp_o, output logic bid_o);
    int n, w_to;
    logic [5:0] idx;
    @(negedge clk);
    awvalid = 1; awaddr = addr; awlen = len[7:0]; awid = id;
    n = 0;
    while (!awready && n < WAIT_MAX) begin @(negedge clk); n++; end
    check_eq("aw_wait", 64'(n >= WAIT_MAX), 64'd0);
    @(negedge clk);
    awvalid = 0;
    w_to = 0;
    for (int i = 0; i <= len; i++) begin
      wvalid = 1; wdata = wbeat[i]; wstrb = strb; wlast = (i == wlast_at);
      n = 0;
      while (!wready && n < WAIT_MAX) begin @(negedge clk); n++; end
      if (n >= WAIT_MAX) w_to++;
      idx = 6'(addr[8:3] + 6'(i));
      for (int b = 0; b < 8; b++) if (strb[b]) model[idx][b*8 +: 8] = wbeat[i][b*8 +: 8];
      @(negedge clk);
    end
    wvalid = 0; wlast = 0;
    check_eq("w_beats_accepted", 64'(w_to), 64'd0);
    n = 0;
    while (!bvalid && n < WAIT_MAX) begin @(negedge clk); n++; end
    check_eq("b_wait", 64'(n >= WAIT_MAX), 64'd0);
    resp_o = bresp; bid_o = bid;
    bready = 1;
    @(negedge clk);
    bready = 0;
    check_eq("b_done_wready", 64'({bvalid, wready}), 64'd0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int len, input logic id, input bit rand_rdy);
    int n, cyc;
    bit started, hold_v;
    logic [63:0] hold_d;
    logic [2:0] hold_f;
    rd_n = 0; rd_gaps = 0; rd_unstable = 0; rd_first_lat = -1;
    @(negedge clk);
    arvalid = 1; araddr = addr; arlen = len[7:0]; arid = id;
    n = 0;
    while (!arready && n < WAIT_MAX) begin @(negedge clk); n++; end
    check_eq("ar_wait", 64'(n >= WAIT_MAX), 64'd0);
    @(negedge clk);
    arvalid = 0;
    cyc = 1; started = 0; hold_v = 0; hold_d = '0; hold_f = '0;
    while (rd_n <= len && cyc < 3000) begin
      rready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rvalid) begin
        if (!started) begin started = 1; rd_first_lat = cyc; end
        if (hold_v && (rdata !== hold_d || {rlast, rresp} !== hold_f)) rd_unstable++;
        if (rready) begin
          rd_data[rd_n] = rdata; rd_resp[rd_n] = rresp; rd_last[rd_n] = rlast; rd_id[rd_n] = rid;
          rd_n++;
          hold_v = 0;
        end else begin
          hold_v = 1; hold_d = rdata; hold_f = {rlast, rresp};
        end
      end else if (started) begin
        rd_gaps++;
      end
      @(negedge clk);
      cyc++;
    end
    rready = 0;
    check_eq("r_wait", 64'(cyc >= 3000), 64'd0);
    check_eq("r_beat_count", 64'(rd_n), 64'(len + 1));
    check_eq("r_gaps", 64'(rd_gaps), 64'd0);
    check_eq("r_stall_stable", 64'(rd_unstable), 64'd0);
    check_eq("r_done_arready", 64'({arready, rvalid}), 64'b10);
  endtask

  initial begin #1_000_000; $display("FAIL global_timeout: simulation did not finish"); $fatal(1); end

  initial begin
    int n, bad_last, bad_resp;
    logic [63:0] exp_d;
    logic [1:0]  exp_r;

    // 1. reset state and release
    #12;
    check_eq("rst_outputs", 64'({awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, bid, rid}), 64'd0);
    check_eq("rst_rdata", rdata, 64'd0);
    @(negedge clk); rst = 0;
    @(negedge clk);
    check_eq("rel_ready", 64'({awready, arready}), 64'b11);
    check_eq("rel_valids", 64'({bvalid, rvalid, wready}), 64'd0);

    // fill the whole RAM with a known pattern
    for (int i = 0; i < 64; i++) wbeat[i] = {16'hF111, 16'(i), 16'hAB00, 16'(i)};
    axi_write(32'h0, 63, 1'b0, 63, 8'hFF, resp, bid_s);
    check_eq("fill_bresp", 64'(resp), 64'd0);

    // 2. 4-beat write/read at 0x40
    for (int i = 0; i < 4; i++) wbeat[i] = 64'hCAFE_0000_0000_0010 + 64'(i);
    axi_write(32'h40, 3, 1'b1, 3, 8'hFF, resp, bid_s);
    check_eq("t2_bresp", 64'(resp), 64'd0);
    check_eq("t2_bid", 64'(bid_s), 64'd1);
    axi_read(32'h40, 3, 1'b1, 1'b0);
    check_eq("t2_first_rvalid_lat", 64'(rd_first_lat), 64'd2);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t2_rdata%0d", i), rd_data[i], 64'hCAFE_0000_0000_0010 + 64'(i));
      check_eq($sformatf("t2_rlast%0d", i), 64'(rd_last[i]), 64'(i == 3));
      check_eq($sformatf("t2_rresp%0d", i), 64'(rd_resp[i]), 64'd0);
    end
    check_eq("t2_rid", 64'(rd_id[0]), 64'd1);

    // 1b. reset in the middle of a read burst
    @(negedge clk);
    arvalid = 1; araddr = 32'h0; arlen = 8'd7; arid = 0; rready = 1;
    n = 0;
    while (!arready && n < WAIT_MAX) begin @(negedge clk); n++; end
    @(negedge clk); arvalid = 0;
    n = 0;
    while (!rvalid && n < WAIT_MAX) begin @(negedge clk); n++; end
    check_eq("rstmid_started", 64'(rvalid), 64'd1);
    @(negedge clk);
    rst = 1; #1;
    check_eq("rstmid_rvalid", 64'({rvalid, rlast, arready, awready}), 64'd0);
    check_eq("rstmid_rdata", rdata, 64'd0);
    @(negedge clk); rst = 0;
    @(negedge clk);
    check_eq("rstmid_rel_ready", 64'({awready, arready}), 64'b11);
    n = 0;
    repeat (5) begin @(negedge clk); if (rvalid) n++; end
    check_eq("rstmid_no_beats", 64'(n), 64'd0);
    rready = 0;

    // 3. partial strobe over word 20 (known fill value F111_0014_AB00_0014)
    wbeat[0] = 64'h1111_2222_3333_4444;
    axi_write(32'hA0, 0, 1'b0, 0, 8'h0F, resp, bid_s);
    check_eq("t3_bresp", 64'(resp), 64'd0);
    axi_read(32'hA0, 0, 1'b0, 1'b0);
    check_eq("t3_rdata", rd_data[0], 64'hF111_0014_3333_4444);
    check_eq("t3_rlast", 64'(rd_last[0]), 64'd1);

    // 5. wlast early on a len-3 burst at 0x100
    for (int i = 0; i < 4; i++) wbeat[i] = 64'h5A5A_0000_0000_0000 + 64'(i);
    axi_write(32'h100, 3, 1'b0, 1, 8'hFF, resp, bid_s);
    check_eq("t5_bresp_slverr", 64'(resp), 64'd2);

    // 4. 256-beat read with random back-pressure
    axi_read(32'h0, 255, 1'b0, 1'b1);
    bad_last = 0; bad_resp = 0;
    for (int i = 0; i < 256; i++) begin
`ifdef AXI_RAM_BOUNDS_EN
      exp_d = (i < 64) ? model[i] : 64'd0;
      exp_r = (i < 64) ? 2'b00 : 2'b10;
`else
      exp_d = model[i % 64];
      exp_r = 2'b00;
`endif
      if (rd_data[i] !== exp_d) check_eq($sformatf("t4_rdata%0d", i), rd_data[i], exp_d);
      if (rd_last[i] !== (i == 255)) bad_last++;
      if (rd_resp[i] !== exp_r) bad_resp++;
    end
    check_eq("t4_beat0", rd_data[0], 64'hF111_0000_AB00_0000);
    check_eq("t4_beat9", rd_data[9], 64'hCAFE_0000_0000_0011);
    check_eq("t4_beat33", rd_data[33], 64'h5A5A_0000_0000_0001);
    check_eq("t4_rlast_pattern", 64'(bad_last), 64'd0);
    check_eq("t4_rresp_pattern", 64'(bad_resp), 64'd0);

    // 6. read above the RAM depth (byte 0x210 -> word 2 modulo depth)
    axi_read(32'h210, 1, 1'b0, 1'b0);
`ifdef AXI_RAM_BOUNDS_EN
    check_eq("t6_rdata0", rd_data[0], 64'd0);
    check_eq("t6_rdata1", rd_data[1], 64'd0);
    check_eq("t6_rresp0", 64'(rd_resp[0]), 64'd2);
    check_eq("t6_rresp1", 64'(rd_resp[1]), 64'd2);
`else
    check_eq("t6_rdata0", rd_data[0], 64'hF111_0002_AB00_0002);
    check_eq("t6_rdata1", rd_data[1], 64'hF111_0003_AB00_0003);
    check_eq("t6_rresp0", 64'(rd_resp[0]), 64'd0);
    check_eq("t6_rresp1", 64'(rd_resp[1]), 64'd0);
`endif
    check_eq("t6_rlast", 64'({rd_last[0], rd_last[1]}), 64'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
